// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter between the RISC_16 CPU
// and the host/loader port.
package dmem_arbiter_pkg;
  localparam int DMEM_ADDR_W = 3;
  localparam int DMEM_DATA_W = 16;
  localparam int HOST_MAX_WAIT = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CPU_RD  = 2'd1,
    ST_HOST_RD = 2'd2
  } state_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, host and dmem bus signals seen by the arbiter.
// The slave modport is the arbiter side; the master modport is the environment side.
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
);
  logic              i_cpu_rd;
  logic              i_cpu_wr;
  logic [ADDR_W-1:0] i_cpu_addr;
  logic [DATA_W-1:0] i_cpu_wdata;
  logic [DATA_W-1:0] o_cpu_rdata;
  logic              o_cpu_rvalid;
  logic              o_cpu_stall;
  logic              i_host_req;
  logic              i_host_we;
  logic [ADDR_W-1:0] i_host_addr;
  logic [DATA_W-1:0] i_host_wdata;
  logic              o_host_ack;
  logic [DATA_W-1:0] o_host_rdata;
  logic              o_dmem_en;
  logic              o_dmem_wen;
  logic [ADDR_W-1:0] o_dmem_addr;
  logic [DATA_W-1:0] o_dmem_wdata;
  logic [DATA_W-1:0] i_dmem_rdata;

  modport slave (
    input  i_cpu_rd, i_cpu_wr, i_cpu_addr, i_cpu_wdata,
    output o_cpu_rdata, o_cpu_rvalid, o_cpu_stall,
    input  i_host_req, i_host_we, i_host_addr, i_host_wdata,
    output o_host_ack, o_host_rdata,
    output o_dmem_en, o_dmem_wen, o_dmem_addr, o_dmem_wdata,
    input  i_dmem_rdata
  );

  modport master (
    output i_cpu_rd, i_cpu_wr, i_cpu_addr, i_cpu_wdata,
    input  o_cpu_rdata, o_cpu_rvalid, o_cpu_stall,
    output i_host_req, i_host_we, i_host_addr, i_host_wdata,
    input  o_host_ack, o_host_rdata,
    input  o_dmem_en, o_dmem_wen, o_dmem_addr, o_dmem_wdata,
    output i_dmem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port dmem arbiter: the CPU has priority, the host gets a forced grant
// after MAX_WAIT denied idle cycles, and a CPU access stalls the CPU until it completes.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int MAX_WAIT = HOST_MAX_WAIT
) (
  input logic           i_clk,
  input logic           i_rst,
  dmem_arbiter_if.slave bus
);
  state_t            state, state_nxt;
  logic [3:0]        wait_cnt, wait_nxt;
  logic              host_wack;
  logic [DATA_W-1:0] cpu_rdata_q, host_rdata_q;
  logic              cpu_req, host_req, host_force, cpu_go, host_go;

  always_comb begin
    cpu_req    = bus.i_cpu_rd | bus.i_cpu_wr;
    // A request still high in the write-ack cycle is the one being acked.
    host_req   = bus.i_host_req & ~host_wack;
    host_force = host_req && (wait_cnt == 4'(MAX_WAIT));
    cpu_go     = 1'b0;
    host_go    = 1'b0;
    if (state == ST_IDLE) begin
      if (host_force)   host_go = 1'b1;
      else if (cpu_req) cpu_go  = 1'b1;
      else if (host_req) host_go = 1'b1;
    end

    state_nxt = ST_IDLE;
    if (cpu_go && !bus.i_cpu_wr)   state_nxt = ST_CPU_RD;
    if (host_go && !bus.i_host_we) state_nxt = ST_HOST_RD;

    wait_nxt = wait_cnt;
    if (!host_req || host_go)                       wait_nxt = 4'd0;
    else if (cpu_go && wait_cnt != 4'(MAX_WAIT))    wait_nxt = wait_cnt + 4'd1;
  end

  always_comb begin
    bus.o_dmem_en    = 1'b0;
    bus.o_dmem_wen   = 1'b0;
    bus.o_dmem_addr  = '0;
    bus.o_dmem_wdata = '0;
    bus.o_cpu_rdata  = '0;
    bus.o_cpu_rvalid = 1'b0;
    bus.o_cpu_stall  = 1'b0;
    bus.o_host_ack   = 1'b0;
    bus.o_host_rdata = '0;
    if (!i_rst) begin
      if (cpu_go) begin
        bus.o_dmem_en    = 1'b1;
        bus.o_dmem_wen   = bus.i_cpu_wr;
        bus.o_dmem_addr  = bus.i_cpu_addr;
        bus.o_dmem_wdata = bus.i_cpu_wr ? bus.i_cpu_wdata : '0;
      end else if (host_go) begin
        bus.o_dmem_en    = 1'b1;
        bus.o_dmem_wen   = bus.i_host_we;
        bus.o_dmem_addr  = bus.i_host_addr;
        bus.o_dmem_wdata = bus.i_host_we ? bus.i_host_wdata : '0;
      end
      bus.o_cpu_rvalid = (state == ST_CPU_RD);
      bus.o_cpu_rdata  = (state == ST_CPU_RD) ? bus.i_dmem_rdata : cpu_rdata_q;
      bus.o_host_ack   = (state == ST_HOST_RD) || host_wack;
      bus.o_host_rdata = (state == ST_HOST_RD) ? bus.i_dmem_rdata : host_rdata_q;
      // Only a granted store or the load-return cycle lets the CPU advance.
      bus.o_cpu_stall  = cpu_req && !(cpu_go && bus.i_cpu_wr) && (state != ST_CPU_RD);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      wait_cnt     <= 4'd0;
      host_wack    <= 1'b0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      host_wack <= host_go && bus.i_host_we;
      if (state == ST_CPU_RD)  cpu_rdata_q  <= bus.i_dmem_rdata;
      if (state == ST_HOST_RD) host_rdata_q <= bus.i_dmem_rdata;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 8x16 single-port dmem.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  logic [15:0] mem [8];
  logic [15:0] mem_rd;

  always #5 clk = ~clk;

  dmem_arbiter_if bus ();
  dmem_arbiter dut (.i_clk(clk), .i_rst(rst), .bus(bus.slave));

  always @(posedge clk) begin
    if (bus.o_dmem_en) begin
      if (bus.o_dmem_wen) mem[bus.o_dmem_addr] <= bus.o_dmem_wdata;
      else                mem_rd <= mem[bus.o_dmem_addr];
    end
  end
  assign bus.i_dmem_rdata = mem_rd;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.i_cpu_rd = 0; bus.i_cpu_wr = 0; bus.i_cpu_addr = '0; bus.i_cpu_wdata = '0;
    bus.i_host_req = 0; bus.i_host_we = 0; bus.i_host_addr = '0; bus.i_host_wdata = '0;
  endtask

  // {en, wen, addr, wdata}
  function automatic logic [31:0] dm();
    return {12'd0, bus.o_dmem_en, bus.o_dmem_wen, bus.o_dmem_addr, bus.o_dmem_wdata};
  endfunction

  function automatic logic [31:0] dm_exp(input logic en, input logic wen,
                                         input logic [2:0] a, input logic [15:0] d);
    return {12'd0, en, wen, a, d};
  endfunction

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = '0;
    mem_rd = '0;
    idle_in();
    bus.i_cpu_wr = 1; bus.i_cpu_addr = 3'd2; bus.i_cpu_wdata = 16'hFFFF;
    @(negedge clk);
    chk("rst_dmem", dm(), 32'd0);
    chk("rst_cpu", {bus.o_cpu_stall, bus.o_cpu_rvalid, bus.o_cpu_rdata}, 32'd0);
    cyc();
    rst = 0;
    idle_in();

    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("idle_outs", {dm()[22:0], bus.o_cpu_stall, bus.o_cpu_rvalid, bus.o_host_ack}, 32'd0);
      if (c == 0) chk("idle_rdata", {bus.o_cpu_rdata, bus.o_host_rdata}, 32'd0);
      cyc();
    end

    // CPU store then load
    bus.i_cpu_wr = 1; bus.i_cpu_addr = 3'd3; bus.i_cpu_wdata = 16'hBEEF;
    @(negedge clk);
    chk("st_dmem", dm(), dm_exp(1, 1, 3, 16'hBEEF));
    chk("st_stall", bus.o_cpu_stall, 0);
    cyc();
    bus.i_cpu_wr = 0; bus.i_cpu_rd = 1;
    @(negedge clk);
    chk("ld_issue", dm(), dm_exp(1, 0, 3, 0));
    chk("ld_stall", bus.o_cpu_stall, 1);
    cyc();
    @(negedge clk);
    chk("ld_ret", {bus.o_cpu_rvalid, bus.o_cpu_stall, bus.o_dmem_en, bus.o_cpu_rdata}, {13'd0, 3'b100, 16'hBEEF});
    cyc();
    bus.i_cpu_rd = 0;
    @(negedge clk);
    chk("ld_done", {bus.o_cpu_rvalid, bus.o_cpu_stall}, 0);
    cyc();

    // Host write then read, request kept high through the write ack
    bus.i_host_req = 1; bus.i_host_we = 1; bus.i_host_addr = 3'd5; bus.i_host_wdata = 16'h1234;
    @(negedge clk);
    chk("hw_issue", dm(), dm_exp(1, 1, 5, 16'h1234));
    chk("hw_noack", bus.o_host_ack, 0);
    cyc();
    @(negedge clk);
    chk("hw_ack", {bus.o_host_ack, bus.o_dmem_en}, 32'b10);
    cyc();
    bus.i_host_we = 0;
    @(negedge clk);
    chk("hr_issue", dm(), dm_exp(1, 0, 5, 0));
    chk("hr_noack", bus.o_host_ack, 0);
    cyc();
    @(negedge clk);
    chk("hr_ack", {bus.o_host_ack, bus.o_dmem_en, bus.o_host_rdata}, {14'd0, 2'b10, 16'h1234});
    cyc();
    bus.i_host_req = 0;
    @(negedge clk);
    chk("hr_done", bus.o_host_ack, 0);
    cyc();

    // CPU loads back-to-back starve the host until the forced grant
    bus.i_cpu_rd = 1; bus.i_cpu_addr = 3'd3;
    bus.i_host_req = 1; bus.i_host_we = 0; bus.i_host_addr = 3'd5;
    for (int c = 0; c < 10; c++) begin
      logic       e_en, e_stall;
      logic [2:0] e_a;
      e_en    = (c % 2 == 0);
      e_a     = (c == 8) ? 3'd5 : (e_en ? 3'd3 : 3'd0);
      e_stall = (c % 2 == 0) || (c == 9);
      @(negedge clk);
      chk($sformatf("starve_c%0d", c),
          {bus.o_dmem_en, bus.o_dmem_addr, bus.o_cpu_stall, bus.o_cpu_rvalid, bus.o_host_ack},
          {25'd0, e_en, e_a, e_stall, (c % 2 == 1) && (c < 9), c == 9});
      if (c == 9) begin
        chk("starve_rdata", bus.o_host_rdata, 16'h1234);
        chk("wait_clr", dut.wait_cnt, 0);
      end
      cyc();
    end
    idle_in();
    cyc();

    // Simultaneous writes to addr 1: CPU first, host next cycle
    bus.i_cpu_wr = 1; bus.i_cpu_addr = 3'd1; bus.i_cpu_wdata = 16'hAAAA;
    bus.i_host_req = 1; bus.i_host_we = 1; bus.i_host_addr = 3'd1; bus.i_host_wdata = 16'h5555;
    @(negedge clk);
    chk("coll_cpu", dm(), dm_exp(1, 1, 1, 16'hAAAA));
    chk("coll_stall", bus.o_cpu_stall, 0);
    cyc();
    bus.i_cpu_wr = 0;
    @(negedge clk);
    chk("coll_host", dm(), dm_exp(1, 1, 1, 16'h5555));
    cyc();
    @(negedge clk);
    chk("coll_ack", bus.o_host_ack, 1);
    chk("coll_mem", mem[1], 16'h5555);
    cyc();
    idle_in();
    cyc();

    // Reset while a CPU load is in flight
    bus.i_cpu_rd = 1; bus.i_cpu_addr = 3'd3;
    @(negedge clk);
    chk("rstld_issue", bus.o_cpu_stall, 1);
    cyc();
    rst = 1;
    @(negedge clk);
    chk("rstld_mid", {bus.o_cpu_rvalid, bus.o_cpu_stall}, 0);
    cyc();
    rst = 0;
    bus.i_cpu_rd = 0;
    @(negedge clk);
    chk("rstld_after", {bus.o_cpu_rvalid, bus.o_cpu_stall, bus.o_dmem_en, bus.o_cpu_rdata}, 0);
    chk("rstld_state", dut.state, ST_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory between the RISC_16 datapath (CPU port) and an external host/loader port (program load, debug peek/poke). It issues at most one dmem access per cycle, gives the CPU default priority with a bounded-wait guarantee for the host, and stalls the PC/GPR write-back while a CPU access is pending. It sits between the control unit/ALU outputs and the dmem instance.

Parameters:
ADDR_W, 3, dmem word-address width (8 words)
DATA_W, 16, data width
MAX_WAIT, 4, consecutive denied host cycles before the host is forced a grant (1..15)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_cpu_rd  in  1  CPU load request (Mem_rd)
i_cpu_wr  in  1  CPU store request (Mem_wr)
i_cpu_addr  in  ADDR_W  CPU address (ALU result low bits)
i_cpu_wdata  in  DATA_W  CPU store data
o_cpu_rdata  out  DATA_W  CPU load data, valid when o_cpu_rvalid
o_cpu_rvalid  out  1  one-cycle pulse, load data returned
o_cpu_stall  out  1  hold PC and suppress GPR write this cycle
i_host_req  in  1  host request, held until ack
i_host_we  in  1  host write (1) / read (0), stable while req
i_host_addr  in  ADDR_W  host address
i_host_wdata  in  DATA_W  host write data
o_host_ack  out  1  one-cycle completion pulse
o_host_rdata  out  DATA_W  host read data, valid with ack on reads
o_dmem_en  out  1  dmem enable
o_dmem_wen  out  1  dmem write enable
o_dmem_addr  out  ADDR_W  dmem address
o_dmem_wdata  out  DATA_W  dmem write data
i_dmem_rdata  in  DATA_W  dmem read data, valid one cycle after read issue

Behaviour:
- One clock i_clk; i_rst synchronous, active-high. Reset: state IDLE, wait counter 0, all outputs 0 (rdata registers 0).
- States: IDLE (may issue), CPU_RD (CPU read in flight), HOST_RD (host read in flight). A write completes in its issue cycle; the FSM stays in IDLE.
- IDLE arbitration (combinational on inputs, registered state):
  - host_force = i_host_req && wait_cnt == MAX_WAIT.
  - host_force: issue host access; CPU request (if any) sees o_cpu_stall=1.
  - else CPU request: issue CPU access; pending host request not granted, wait_cnt++ (saturates at MAX_WAIT).
  - else host request: issue host access.
  - wait_cnt clears to 0 on every host grant and whenever i_host_req=0.
- CPU write: dmem en=wen=1 in the grant cycle; o_cpu_stall=0 (zero-stall store).
- CPU read: issued in cycle N with o_cpu_stall=1; state CPU_RD; in N+1 o_cpu_rdata=i_dmem_rdata, o_cpu_rvalid=1, o_cpu_stall=0, no new dmem access that cycle; return to IDLE. Load latency = 1 stall cycle.
- i_cpu_rd and i_cpu_wr both high: treated as write.
- Host write: issued cycle N; o_host_ack=1 in N+1. Host read: issued N, state HOST_RD; N+1 o_host_rdata captured, o_host_ack=1; IDLE. Host must drop or change req after ack; req seen high in the ack cycle is not re-granted until the next cycle.
- Any CPU request arriving while in CPU_RD/HOST_RD: o_cpu_stall=1.
- o_cpu_stall = CPU request present && not completed this cycle; never asserted with no CPU request.
- Reset mid-access: in-flight read discarded, no rvalid/ack emitted.
- No back-to-back dmem access in a read-return cycle; dmem sees at most one access per cycle (en=0 when idle, addr/wdata 0).

Decomposition:
- Shared package: state encoding constants (ST_IDLE, ST_CPU_RD, ST_HOST_RD), ADDR_W/DATA_W defaults matching dmem.
- No sub-module needed; the optional saturating wait counter may be a sub-module named sat_counter.

Test Plan:
- Reset then idle: all outputs 0, o_dmem_en=0 for 5 cycles.
- CPU store addr 3 data 0xBEEF then load addr 3 -> store: stall 0, wen=1; load: stall 1 cycle, next cycle rvalid=1, rdata=0xBEEF.
- Host write addr 5 = 0x1234 then read addr 5 with CPU idle -> ack 1 cycle after each issue, read ack with rdata=0x1234.
- CPU load every cycle + host read held, MAX_WAIT=4 -> host denied 4 times, then granted; CPU stalled in that cycle; wait_cnt back to 0.
- Simultaneous CPU write and host write to addr 1 (wait_cnt 0) -> CPU write wins; host write the following cycle; final mem[1]=host data.
- i_rst asserted during CPU_RD -> no rvalid next cycle, state IDLE, stall 0.
